// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
//   Front-end conditioner for the 12-key keypad. Synchronises the raw key lines, debounces press
//   and release, rejects multi-key chords, and emits one strobe per accepted press. While a key
//   is held it can also emit auto-repeat strobes.
//
// Ports
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   keypad_in  raw key lines, 1 = pressed; bit i = key i (0-9 digits, 10 = '*', 11 = '#')
//   key_valid  one-cycle strobe, key_code is valid
//   key_code   code of the accepted key (0-11), held between strobes
//   key_repeat high together with key_valid when the strobe is an auto-repeat
//   key_held   high while a debounced key is held
//   key_error  one-cycle pulse when a multi-key chord is rejected
module keypad_scan_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned CNT_W           = 25
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [11:0] keypad_in,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_repeat,
  output logic        key_held,
  output logic        key_error
);

  localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam bit               DebOne    = (DEBOUNCE_CYCLES <= 1);

  typedef enum logic [2:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait,
    StChord
  } state_e;

  state_e           state_q;
  logic [11:0]      sync1_q, sync2_q;
  logic [3:0]       cand_q;
  // cnt_q counts consecutive qualifying cycles, including the cycle that entered the state, so
  // reaching DebLast means DEBOUNCE_CYCLES stable samples have been seen.
  logic [CNT_W-1:0] cnt_q;
  // rcnt_q counts held cycles since the last strobe; rep_first_q selects delay vs. rate target.
  logic [CNT_W-1:0] rcnt_q;
  logic             rep_first_q;

  logic             s_none, s_multi, s_single, s_is_cand;
  logic [3:0]       s_idx;
  logic [11:0]      cand_onehot;
  logic [CNT_W-1:0] rep_last;
  logic             press_fire;
  logic [3:0]       press_code;

  // Two-flop synchroniser; everything downstream looks only at sync2_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= keypad_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    s_none   = (sync2_q == 12'h000);
    // Clearing the lowest set bit leaves something behind only if two or more bits were set.
    s_multi  = ((sync2_q & (sync2_q - 12'h001)) != 12'h000);
    s_single = !s_none && !s_multi;
    s_idx    = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (sync2_q[i]) s_idx = 4'(i);
    end
    cand_onehot = 12'h001 << cand_q;
    s_is_cand   = (sync2_q == cand_onehot);
    rep_last    = rep_first_q ? DelayLast : RateLast;

    press_fire = 1'b0;
    press_code = cand_q;
    if (state_q == StIdle && s_single && DebOne) begin
      press_fire = 1'b1;
      press_code = s_idx;
    end
    if (state_q == StPressWait && s_is_cand && cnt_q >= DebLast) begin
      press_fire = 1'b1;
    end
  end

  // Counters stop at their terminal value and are then reloaded, so they never wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cand_q      <= '0;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      rep_first_q <= 1'b1;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_repeat  <= 1'b0;
      key_held    <= 1'b0;
      key_error   <= 1'b0;
    end else begin
      key_valid  <= 1'b0;
      key_repeat <= 1'b0;
      key_error  <= 1'b0;
      if (press_fire) begin
        key_valid   <= 1'b1;
        key_code    <= press_code;
        cand_q      <= press_code;
        key_held    <= 1'b1;
        rcnt_q      <= '0;
        rep_first_q <= 1'b1;
        state_q     <= StHeld;
      end else begin
        unique case (state_q)
          StIdle: begin
            // A chord arriving from all-released is ignored until it resolves to one key.
            if (s_single) begin
              cand_q  <= s_idx;
              cnt_q   <= CntOne;
              state_q <= StPressWait;
            end
          end
          StPressWait: begin
            if (s_is_cand) begin
              cnt_q <= cnt_q + CntOne;
            end else if (s_multi) begin
              key_error <= 1'b1;
              cnt_q     <= '0;
              state_q   <= StChord;
            end else begin
              state_q <= StIdle;
            end
          end
          StHeld: begin
            if (s_is_cand) begin
              if (REPEAT_EN) begin
                if (rcnt_q >= rep_last) begin
                  key_valid   <= 1'b1;
                  key_repeat  <= 1'b1;
                  rcnt_q      <= '0;
                  rep_first_q <= 1'b0;
                end else begin
                  rcnt_q <= rcnt_q + CntOne;
                end
              end
            end else if (s_none && DebOne) begin
              key_held <= 1'b0;
              state_q  <= StIdle;
            end else begin
              cnt_q   <= s_none ? CntOne : '0;
              state_q <= StReleaseWait;
            end
          end
          StReleaseWait: begin
            // Return on a bounce keeps the repeat phase; another key only restarts the release.
            if (s_is_cand) begin
              state_q <= StHeld;
            end else if (s_none) begin
              if (cnt_q >= DebLast) begin
                key_held <= 1'b0;
                state_q  <= StIdle;
              end else begin
                cnt_q <= cnt_q + CntOne;
              end
            end else begin
              cnt_q <= '0;
            end
          end
          StChord: begin
            if (s_none) begin
              if (cnt_q >= DebLast) begin
                state_q <= StIdle;
              end else begin
                cnt_q <= cnt_q + CntOne;
              end
            end else begin
              cnt_q <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Self-checking bench for keypad_scan_debounce. Two instances share the stimulus: one with
// auto-repeat enabled, one with it disabled. A timestamp/run-length reference model predicts all
// outputs every cycle; directed steps add scenario-level counts and latencies.
module tb_keypad_scan_debounce;

  localparam int DEB   = 4;
  localparam int RDLY  = 20;
  localparam int RRATE = 5;

  localparam int MIdle  = 0;
  localparam int MArmed = 1;
  localparam int MHeld  = 2;
  localparam int MRel   = 3;
  localparam int MChord = 4;

  typedef struct {
    logic [11:0] s1;
    logic [11:0] s2;
    int          mode;
    int          key;
    int          t0;
    int          held_n;
    int          next_rep;
    int          none_run;
    logic        valid;
    logic        rep;
    logic        held;
    logic        err;
    logic [3:0]  code;
  } model_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [11:0] keypad;
  logic        va, ra, ha, ea, vb, rb, hb, eb;
  logic [3:0]  ca, cb;

  int     n_cmp, n_fail, cyc;
  model_t ma, mb;
  int     str_a, rep_a, err_a, both_a, first_a, rep1_a, replast_a, fall_a;
  int     str_b, rep_b, both_b;
  logic [3:0] code_a, code_b;
  logic   ha_prev;
  int     c0, c1;

  always #5 clk = ~clk;

  keypad_scan_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_RATE    (RRATE),
    .REPEAT_EN      (1'b1),
    .CNT_W          (8)
  ) u_dut_a (
    .clk       (clk),
    .resetn    (resetn),
    .keypad_in (keypad),
    .key_valid (va),
    .key_code  (ca),
    .key_repeat(ra),
    .key_held  (ha),
    .key_error (ea)
  );

  keypad_scan_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_RATE    (RRATE),
    .REPEAT_EN      (1'b0),
    .CNT_W          (8)
  ) u_dut_b (
    .clk       (clk),
    .resetn    (resetn),
    .keypad_in (keypad),
    .key_valid (vb),
    .key_code  (cb),
    .key_repeat(rb),
    .key_held  (hb),
    .key_error (eb)
  );

  function automatic model_t model_reset();
    model_t m;
    m.s1 = '0; m.s2 = '0;
    m.mode = MIdle; m.key = 0; m.t0 = 0; m.held_n = 0; m.next_rep = 0; m.none_run = 0;
    m.valid = 1'b0; m.rep = 1'b0; m.held = 1'b0; m.err = 1'b0; m.code = '0;
    return m;
  endfunction

  // One clock edge of the reference: s is what the logic sees after two register stages.
  function automatic model_t model_step(model_t mi, logic [11:0] pad, int n, bit rep_en);
    model_t      m;
    logic [11:0] s;
    int          ones;
    bit          is_key;
    m = mi;
    s = m.s2;
    m.s2 = m.s1;
    m.s1 = pad;
    m.valid = 1'b0; m.rep = 1'b0; m.err = 1'b0;
    ones   = $countones(s);
    is_key = (ones == 1) && ($clog2(s) == m.key);
    case (m.mode)
      MIdle: begin
        if (ones == 1) begin
          m.key = $clog2(s); m.t0 = n; m.mode = MArmed;
        end
      end
      MArmed: begin
        if (is_key) begin
          if (n - m.t0 + 1 >= DEB) begin
            m.valid = 1'b1; m.code = 4'(m.key); m.held = 1'b1; m.mode = MHeld;
            m.held_n = 0; m.next_rep = RDLY;
          end
        end else if (ones >= 2) begin
          m.err = 1'b1; m.mode = MChord; m.none_run = 0;
        end else begin
          m.mode = MIdle;
        end
      end
      MHeld: begin
        if (is_key) begin
          if (rep_en) begin
            m.held_n = m.held_n + 1;
            if (m.held_n == m.next_rep) begin
              m.valid = 1'b1; m.rep = 1'b1; m.next_rep = m.next_rep + RRATE;
            end
          end
        end else begin
          m.mode = MRel; m.none_run = (ones == 0) ? 1 : 0;
        end
      end
      MRel: begin
        if (is_key) m.mode = MHeld;
        else if (ones == 0) begin
          m.none_run = m.none_run + 1;
          if (m.none_run >= DEB) begin m.held = 1'b0; m.mode = MIdle; end
        end else m.none_run = 0;
      end
      default: begin
        if (ones == 0) begin
          m.none_run = m.none_run + 1;
          if (m.none_run >= DEB) m.mode = MIdle;
        end else m.none_run = 0;
      end
    endcase
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    str_a = 0; rep_a = 0; err_a = 0; first_a = -1; rep1_a = -1; replast_a = -1; fall_a = -1;
    str_b = 0; rep_b = 0; code_a = '0; code_b = '0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      if (!resetn) begin
        ma = model_reset();
        mb = model_reset();
      end else begin
        ma = model_step(ma, keypad, cyc, 1'b1);
        mb = model_step(mb, keypad, cyc, 1'b0);
      end
      #1;
      check("cyc_a", {24'h0, va, ca, ra, ha, ea}, {24'h0, ma.valid, ma.code, ma.rep, ma.held, ma.err});
      check("cyc_b", {24'h0, vb, cb, rb, hb, eb}, {24'h0, mb.valid, mb.code, mb.rep, mb.held, mb.err});
      if (va) begin
        str_a++; code_a = ca;
        if (ra) begin
          rep_a++;
          if (rep1_a < 0) rep1_a = cyc;
          replast_a = cyc;
        end else first_a = cyc;
      end
      if (ea) err_a++;
      if (va && ea) both_a++;
      if (vb && eb) both_b++;
      if (ha_prev && !ha) fall_a = cyc;
      ha_prev = ha;
      if (vb) begin
        str_b++; code_b = cb;
        if (rb) rep_b++;
      end
    end
  endtask

  task automatic hold(input logic [11:0] v, input int n);
    keypad = v;
    tick(n);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; both_a = 0; both_b = 0; ha_prev = 1'b0;
    resetn = 1'b0; keypad = '0;
    ma = model_reset(); mb = model_reset();
    clear_stats();
    tick(3);
    check("reset_a", {24'h0, va, ca, ra, ha, ea}, 32'h0);
    check("reset_b", {24'h0, vb, cb, rb, hb, eb}, 32'h0);
    resetn = 1'b1;
    hold(12'h000, $urandom_range(2, 6));

    // Reset in the middle of a held key.
    hold(12'h020, 10);
    check("held_before_rst", {31'h0, ha}, 32'h1);
    resetn = 1'b0;
    #1;
    ma = model_reset(); mb = model_reset();
    check("rst_async_a", {24'h0, va, ca, ra, ha, ea}, 32'h0);
    check("rst_async_b", {24'h0, vb, cb, rb, hb, eb}, 32'h0);
    tick(1);
    resetn = 1'b1;
    clear_stats();
    c0 = cyc;
    hold(12'h020, 10);
    check("rst_strobes", str_a, 1);
    check("rst_code", {28'h0, code_a}, 32'd5);
    check("rst_latency", first_a - c0, 2 + DEB);
    hold(12'h000, 10 + $urandom_range(0, 5));

    // Clean press of key 3 with auto-repeat.
    clear_stats();
    c0 = cyc;
    hold(12'h008, 40);
    c1 = cyc;
    hold(12'h000, 12);
    check("clean_strobes", str_a, 5);
    check("clean_reps", rep_a, 4);
    check("clean_code", {28'h0, code_a}, 32'd3);
    check("clean_latency", first_a - c0, 2 + DEB);
    check("clean_first_rep", rep1_a - first_a, RDLY);
    check("clean_rep_span", replast_a - rep1_a, 3 * RRATE);
    check("clean_held_fall", fall_a - c1, 2 + DEB);
    check("clean_b_strobes", str_b, 1);
    check("clean_b_reps", rep_b, 0);

    // Press bounce on key 11, then a short release glitch while held.
    clear_stats();
    hold(12'h800, 1); hold(12'h000, 1); hold(12'h800, 1); hold(12'h000, 1);
    hold(12'h800, 10);
    check("bounce_strobes", str_a, 1);
    check("bounce_code", {28'h0, code_a}, 32'd11);
    hold(12'h000, 2);
    hold(12'h800, 10);
    check("glitch_strobes", str_a, 1);
    check("glitch_held", {31'h0, ha}, 32'h1);
    check("glitch_no_fall", {31'h0, fall_a < 0}, 32'h1);
    hold(12'h000, 12);

    // Chord rejection, then a minimal release before a fresh press.
    clear_stats();
    hold(12'h001, 1);
    hold(12'h003, 8);
    check("chord_err", err_a, 1);
    check("chord_no_strobe", str_a, 0);
    hold(12'h001, 10);
    check("chord_single_no_strobe", str_a, 0);
    hold(12'h000, DEB);
    hold(12'h001, 10);
    check("chord_after_strobes", str_a, 1);
    check("chord_after_code", {28'h0, ca}, 32'd0);
    hold(12'h000, 12);

    // Roll-over: key 2, add key 7, drop key 2.
    clear_stats();
    hold(12'h004, 10);
    check("roll_first", str_a, 1);
    check("roll_first_code", {28'h0, ca}, 32'd2);
    hold(12'h084, 6);
    hold(12'h080, 10);
    check("roll_no_second", str_a, 1);
    check("roll_still_held", {31'h0, ha}, 32'h1);
    hold(12'h000, 10);
    check("roll_released", {31'h0, ha}, 32'h0);
    hold(12'h080, 10);
    check("roll_fresh", str_a, 2);
    check("roll_fresh_code", {28'h0, ca}, 32'd7);
    hold(12'h000, 12);

    // Long hold of key 9: instance B must strobe once, instance A keeps repeating.
    clear_stats();
    hold(12'h200, 100);
    hold(12'h000, 12);
    check("norep_b_strobes", str_b, 1);
    check("norep_b_code", {28'h0, code_b}, 32'd9);
    check("norep_b_reps", rep_b, 0);
    check("rep_a_reps", rep_a, (100 + 2 - (2 + DEB) - RDLY) / RRATE + 1);

    // Random soak against the reference model.
    for (int i = 0; i < 250; i++) begin
      int unsigned r, ka, kb, dur;
      logic [11:0] v;
      r  = $urandom_range(0, 9);
      ka = $urandom_range(0, 11);
      kb = (ka + $urandom_range(1, 11)) % 12;
      if (r < 3) v = 12'h000;
      else if (r < 8) v = 12'h001 << ka;
      else v = (12'h001 << ka) | (12'h001 << kb);
      dur = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 10);
      hold(v, int'(dur));
    end
    hold(12'h000, 12);
    check("no_valid_err_overlap_a", both_a, 0);
    check("no_valid_err_overlap_b", both_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
